obi_rr_arbiter: RTL and testbench
=================================

Name: obi_rr_arbiter

Overview:
- Shares one OBI subordinate port among NumMgr OBI manager ports using round-robin arbitration.
- Tracks the owner of each outstanding request in an in-order FIFO and routes each subordinate response back to that manager.
- Sits between crossbar/demux outputs and a single-ported memory or peripheral.
- Uses the default OBI profile: no rready, atop, memtype, prot, user or id signals; gnt is registered-free.

Parameters:
- NumMgr, 4, number of manager ports (>=2).
- AddrWidth, 32, address width.
- DataWidth, 32, data width; byte enable width is DataWidth/8.
- MaxTrans, 2, maximum outstanding granted-but-unresponded transactions (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- mgr_req_i  in  NumMgr  per-manager request.
- mgr_gnt_o  out  NumMgr  per-manager grant.
- mgr_addr_i  in  NumMgr*AddrWidth  packed addresses; manager k at slice k.
- mgr_we_i  in  NumMgr  write enable.
- mgr_be_i  in  NumMgr*DataWidth/8  byte enables.
- mgr_wdata_i  in  NumMgr*DataWidth  write data.
- mgr_rvalid_o  out  NumMgr  response valid, one-hot or zero.
- mgr_rdata_o  out  DataWidth  read data, broadcast to all managers.
- mgr_err_o  out  1  response error, broadcast; qualified by mgr_rvalid_o.
- sbr_req_o  out  1  subordinate request.
- sbr_gnt_i  in  1  subordinate grant.
- sbr_addr_o  out  AddrWidth  selected address.
- sbr_we_o  out  1  selected write enable.
- sbr_be_o  out  DataWidth/8  selected byte enables.
- sbr_wdata_o  out  DataWidth  selected write data.
- sbr_rvalid_i  in  1  subordinate response valid.
- sbr_rdata_i  in  DataWidth  read data.
- sbr_err_i  in  1  response error.

Behaviour:
- Reset values:
  - sbr_req_o=0, mgr_gnt_o=0, mgr_rvalid_o=0.
  - RR pointer=0, lock=0, FIFO empty, counters 0.
- Arbitration:
  - Candidate is the first requesting manager at or after the RR pointer, wrapping modulo NumMgr.
  - Selection is combinational. sbr_req_o = any request AND NOT fifo_full.
  - sbr_* payload is muxed from the selected manager.
- Address-phase stability (OBI rule):
  - If sbr_req_o=1 and sbr_gnt_i=0, the arbiter latches the selected index (lock=1).
  - While locked, it keeps presenting that manager regardless of other requests.
  - Lock clears on the handshake cycle.
- Grant:
  - mgr_gnt_o[sel] = sbr_gnt_i AND sbr_req_o; zero-latency pass-through.
  - On handshake: push sel into FIFO, set RR pointer to (sel+1) mod NumMgr.
- FIFO full (count==MaxTrans):
  - sbr_req_o=0, no grants.
  - A pop in the same cycle does not enable a grant; the grant waits one cycle. This is deterministic by design.
  - A locked selection stays latched while full.
- Response path:
  - On sbr_rvalid_i, pop the FIFO head h.
  - mgr_rvalid_o[h]=1 in the same cycle, combinational.
  - mgr_rdata_o=sbr_rdata_i, mgr_err_o=sbr_err_i.
  - Earliest response is the cycle after the handshake.
- Simultaneous push and pop: count unchanged, both pointers advance.
- sbr_rvalid_i with empty FIFO:
  - Protocol violation; no mgr_rvalid_o asserted, state unchanged.
  - Simulation assertion fires.
- Manager dropping req before gnt: protocol violation, assertion only; the arbiter unlocks if the locked request drops.
- Pointers wrap modulo MaxTrans. Count width is clog2(MaxTrans+1).
- Reset mid-transaction: all state cleared asynchronously; in-flight responses are lost.
- NumMgr=1 is illegal (elaboration assertion).

Optional Feature:
- Macro: OBI_RR_ARBITER_STATS_EN.
- When defined, adds two outputs:
  - stall_cnt_o, 32 bits: cycles with sbr_req_o=1 and sbr_gnt_i=0.
  - full_cnt_o, 32 bits: cycles with any mgr_req_i=1 while the FIFO is full.
- Both counters saturate at 0xFFFFFFFF and reset to 0.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Managers 0 and 2 request continuously, sbr_gnt_i=1, response 1 cycle later -> grants alternate 0,2,0,2; each rvalid goes to the matching manager with its rdata (0xA0 for 0, 0xA2 for 2).
- Manager 1 requests addr 0x100 with sbr_gnt_i=0 for 3 cycles while manager 0 raises req in cycle 2 -> sbr_addr_o stays 0x100 until grant; manager 0 is granted next.
- MaxTrans=2, all 4 managers request, subordinate grants but withholds rvalid -> exactly 2 grants, then sbr_req_o=0; the first rvalid frees a slot and a grant follows one cycle later.
- Responses return with sbr_err_i=1 on the second response -> mgr_err_o=1 only with mgr_rvalid_o of the second granted manager.
- rst_ni pulsed low with 2 outstanding transactions -> all outputs 0 immediately; after release, the RR pointer restarts at manager 0 and stray sbr_rvalid_i is ignored with an assertion.
- With OBI_RR_ARBITER_STATS_EN: 5 cycles of req without gnt -> stall_cnt_o=5. Preload near saturation -> counter holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: shares one OBI subordinate port among NumMgr managers with round-robin arbitration
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   mgr_req_i/mgr_gnt_o      per-manager request / zero-latency grant
//   mgr_addr_i/we/be/wdata   packed per-manager address-phase payload, manager k at slice k
//   mgr_rvalid_o             one-hot response valid routed to the owner of the oldest transaction
//   mgr_rdata_o/mgr_err_o    response data / error broadcast to all managers
//   sbr_*                    single OBI subordinate port
//   stall_cnt_o, full_cnt_o  saturating statistics, present only with OBI_RR_ARBITER_STATS_EN defined
module obi_rr_arbiter #(
    parameter int NumMgr    = 4,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int MaxTrans  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumMgr-1:0]             mgr_req_i,
    output logic [NumMgr-1:0]             mgr_gnt_o,
    input  logic [NumMgr*AddrWidth-1:0]   mgr_addr_i,
    input  logic [NumMgr-1:0]             mgr_we_i,
    input  logic [NumMgr*DataWidth/8-1:0] mgr_be_i,
    input  logic [NumMgr*DataWidth-1:0]   mgr_wdata_i,
    output logic [NumMgr-1:0]             mgr_rvalid_o,
    output logic [DataWidth-1:0]          mgr_rdata_o,
    output logic                          mgr_err_o,
    output logic                          sbr_req_o,
    input  logic                          sbr_gnt_i,
    output logic [AddrWidth-1:0]          sbr_addr_o,
    output logic                          sbr_we_o,
    output logic [DataWidth/8-1:0]        sbr_be_o,
    output logic [DataWidth-1:0]          sbr_wdata_o,
    input  logic                          sbr_rvalid_i,
    input  logic [DataWidth-1:0]          sbr_rdata_i,
    input  logic                          sbr_err_i
`ifdef OBI_RR_ARBITER_STATS_EN
    ,
    output logic [31:0]                   stall_cnt_o,
    output logic [31:0]                   full_cnt_o
`endif
);
    localparam int BeWidth = DataWidth / 8;
    localparam int IdxW    = $clog2(NumMgr);
    localparam int PtrW    = MaxTrans > 1 ? $clog2(MaxTrans) : 1;
    localparam int CntW    = $clog2(MaxTrans + 1);

    if (NumMgr < 2) begin : g_bad_num_mgr
        $error("obi_rr_arbiter: NumMgr must be at least 2");
    end

    logic [IdxW-1:0] rr_ptr, lock_idx, cand, sel;
    logic            lock;
    logic [IdxW-1:0] fifo [MaxTrans];
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [CntW-1:0] cnt;
    logic            full, any_req, hs, pop;

    assign full    = cnt == CntW'(MaxTrans);
    assign any_req = |mgr_req_i;

    // Scan downwards so the requester closest to rr_ptr (wrapping) wins.
    always_comb begin
        cand = rr_ptr;
        for (int i = NumMgr - 1; i >= 0; i--) begin
            logic [IdxW-1:0] j;
            j = IdxW'((int'(rr_ptr) + i) % NumMgr);
            if (mgr_req_i[j]) cand = j;
        end
    end

    // A stalled address phase keeps its manager; dropping that request releases it.
    assign sel          = (lock && mgr_req_i[lock_idx]) ? lock_idx : cand;
    assign sbr_req_o    = rst_ni && any_req && !full;
    assign hs           = sbr_req_o && sbr_gnt_i;
    assign pop          = sbr_rvalid_i && cnt != '0;
    assign mgr_gnt_o    = hs ? NumMgr'(1) << sel : '0;
    assign mgr_rvalid_o = pop ? NumMgr'(1) << fifo[rd_ptr] : '0;
    assign mgr_rdata_o  = sbr_rdata_i;
    assign mgr_err_o    = sbr_err_i;
    assign sbr_addr_o   = mgr_addr_i[sel*AddrWidth +: AddrWidth];
    assign sbr_we_o     = mgr_we_i[sel];
    assign sbr_be_o     = mgr_be_i[sel*BeWidth +: BeWidth];
    assign sbr_wdata_o  = mgr_wdata_i[sel*DataWidth +: DataWidth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
        end else begin
            if (hs) begin
                rr_ptr <= sel == IdxW'(NumMgr - 1) ? '0 : sel + 1'b1;
                lock   <= 1'b0;
                wr_ptr <= wr_ptr == PtrW'(MaxTrans - 1) ? '0 : wr_ptr + 1'b1;
            end else if (sbr_req_o) begin
                lock     <= 1'b1;
                lock_idx <= sel;
            end else if (lock && !mgr_req_i[lock_idx]) begin
                lock <= 1'b0;
            end
            if (pop) rd_ptr <= rd_ptr == PtrW'(MaxTrans - 1) ? '0 : rd_ptr + 1'b1;
            cnt <= cnt + CntW'(hs) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (hs) fifo[wr_ptr] <= sel;
    end

`ifdef OBI_RR_ARBITER_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
            full_cnt_o  <= '0;
        end else begin
            if (sbr_req_o && !sbr_gnt_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
            if (any_req && full && full_cnt_o != '1) full_cnt_o <= full_cnt_o + 1'b1;
        end
    end
`endif

    stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni) sbr_rvalid_i |-> cnt != '0)
        else $error("obi_rr_arbiter: sbr_rvalid_i with no outstanding transaction");

    for (genvar k = 0; k < NumMgr; k++) begin : g_req_hold
        req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   mgr_req_i[k] && !mgr_gnt_o[k] |=> mgr_req_i[k])
            else $error("obi_rr_arbiter: manager %0d dropped req before gnt", k);
    end
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb_obi_rr_arbiter: directed and random checks of obi_rr_arbiter against a queue-based reference model
module tb_obi_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req = '0, gnt_o, rvalid_o;
    logic [N*AW-1:0] addr = '0;
    logic [N-1:0] we = '0;
    logic [N*BW-1:0] be = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [DW-1:0] rdata_o;
    logic err_o;
    logic s_req, s_we;
    logic s_gnt = 1'b0, s_rvalid = 1'b0, s_rerr = 1'b0;
    logic [AW-1:0] s_addr;
    logic [BW-1:0] s_be;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata = '0;
`ifdef OBI_RR_ARBITER_STATS_EN
    logic [31:0] stall_cnt, full_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int rr = 0;
    int lk = -1;
    int q[$];

    always #5 clk = ~clk;

    obi_rr_arbiter #(.NumMgr(N), .AddrWidth(AW), .DataWidth(DW), .MaxTrans(MT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mgr_req_i(req), .mgr_gnt_o(gnt_o), .mgr_addr_i(addr), .mgr_we_i(we),
        .mgr_be_i(be), .mgr_wdata_i(wdata), .mgr_rvalid_o(rvalid_o),
        .mgr_rdata_o(rdata_o), .mgr_err_o(err_o),
        .sbr_req_o(s_req), .sbr_gnt_i(s_gnt), .sbr_addr_o(s_addr), .sbr_we_o(s_we),
        .sbr_be_o(s_be), .sbr_wdata_o(s_wdata), .sbr_rvalid_i(s_rvalid),
        .sbr_rdata_i(s_rdata), .sbr_err_i(s_rerr)
`ifdef OBI_RR_ARBITER_STATS_EN
        , .stall_cnt_o(stall_cnt), .full_cnt_o(full_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Locked manager if it still requests, otherwise first requester at or after rr.
    function automatic int pick();
        if (lk >= 0 && req[lk]) return lk;
        for (int i = 0; i < N; i++) if (req[(rr + i) % N]) return (rr + i) % N;
        return -1;
    endfunction

    task automatic new_payload(input int k);
        addr[k*AW +: AW]  = $urandom;
        we[k]             = 1'($urandom_range(0, 1));
        be[k*BW +: BW]    = BW'($urandom);
        wdata[k*DW +: DW] = $urandom;
    endtask

    // One clock: check combinational outputs at negedge, advance model, return granted index or -1.
    task automatic tick(output int g);
        int s;
        bit full, er;
        logic [N-1:0] eg, ev;
        @(negedge clk);
        full = q.size() == MT;
        s = pick();
        er = s >= 0 && !full;
        eg = (er && s_gnt) ? N'(1) << s : '0;
        ev = (s_rvalid && q.size() != 0) ? N'(1) << q[0] : '0;
        chk("sbr_req", s_req, er);
        chk("mgr_gnt", gnt_o, eg);
        chk("mgr_rvalid", rvalid_o, ev);
        if (ev != 0) chk("rdata_err", {rdata_o, err_o}, {s_rdata, s_rerr});
        if (er) chk("payload", {s_addr, s_we, s_be, s_wdata},
                    {addr[s*AW +: AW], we[s], be[s*BW +: BW], wdata[s*DW +: DW]});
        if (ev != 0) void'(q.pop_front());
        g = eg != 0 ? s : -1;
        if (eg != 0) begin
            q.push_back(s);
            rr = (s + 1) % N;
            lk = -1;
        end else if (er) lk = s;
        else if (lk >= 0 && !req[lk]) lk = -1;
        @(posedge clk);
        #1;
    endtask

    // Grant every pending request and answer every outstanding transaction.
    task automatic settle();
        int g;
        s_gnt = 1'b1;
        for (int c = 0; c < 40 && (req != 0 || q.size() != 0); c++) begin
            s_rvalid = q.size() != 0;
            s_rdata = $urandom;
            s_rerr = 1'b0;
            tick(g);
            if (g >= 0) req[g] = 1'b0;
        end
        s_rvalid = 1'b0;
        chk("settle_idle", {req, 1'(q.size())}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, g1, g2, ng;
        for (int k = 0; k < N; k++) new_payload(k);
        req = '1;
        s_rvalid = 1'b1;
        #12;
        chk("reset_outputs", {s_req, gnt_o, rvalid_o}, '0);
        req = '0;
        s_rvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Managers 0 and 2 alternate; each response returns one cycle after its grant.
        req = 4'b0101;
        s_gnt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            s_rvalid = q.size() != 0;
            s_rdata = q.size() != 0 ? 32'hA0 + 32'(q[0]) : '0;
            tick(g);
            chk("alternate_gnt", g, (c % 2) ? 2 : 0);
        end
        settle();

        // Park rr at 0, then stall manager 1 while manager 0 joins.
        req = 4'b1000;
        tick(g);
        req = '0;
        settle();
        addr[1*AW +: AW] = 32'h100;
        req = 4'b0010;
        s_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) req[0] = 1'b1;
            tick(g);
            chk("lock_addr", s_addr, 32'h100);
        end
        s_gnt = 1'b1;
        tick(g);
        chk("lock_first", g, 1);
        req[1] = 1'b0;
        tick(g);
        chk("lock_next", g, 0);
        req[0] = 1'b0;
        settle();

        // Outstanding limit: two grants, then nothing until a response frees a slot.
        req = '1;
        s_gnt = 1'b1;
        ng = 0;
        for (int c = 0; c < 4; c++) begin
            tick(g);
            if (g >= 0) ng++;
        end
        chk("full_grants", ng, MT);
        chk("full_req_low", s_req, 1'b0);
        s_rvalid = 1'b1;
        tick(g);
        chk("pop_no_gnt", g, -1);
        s_rvalid = 1'b0;
        tick(g);
        chk("gnt_after_pop", g >= 0, 1'b1);
        settle();

        // Error only on the second response.
        req = 4'b1010;
        tick(g1);
        if (g1 >= 0) req[g1] = 1'b0;
        tick(g2);
        if (g2 >= 0) req[g2] = 1'b0;
        s_gnt = 1'b0;
        s_rvalid = 1'b1;
        s_rerr = 1'b0;
        #1;
        chk("err_first", {rvalid_o, err_o}, {N'(1) << g1, 1'b0});
        tick(g);
        s_rerr = 1'b1;
        #1;
        chk("err_second", {rvalid_o, err_o}, {N'(1) << g2, 1'b1});
        tick(g);
        s_rvalid = 1'b0;
        s_rerr = 1'b0;
        settle();

        // Reset with two transactions outstanding.
        req = '1;
        s_gnt = 1'b1;
        tick(g);
        tick(g);
        rst_n = 1'b0;
        #1;
        s_rvalid = 1'b1;
        #1;
        chk("rst_mid_outputs", {s_req, gnt_o, rvalid_o}, '0);
        q.delete();
        rr = 0;
        lk = -1;
        @(posedge clk);
        #1;
        s_rvalid = 1'b0;
        rst_n = 1'b1;
        tick(g);
        chk("rr_restart", g, 0);
        req[0] = 1'b0;
        settle();

        // Random traffic that obeys the protocol.
        req = '0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req[k] && $urandom_range(0, 2) == 0) begin
                    req[k] = 1'b1;
                    new_payload(k);
                end
            end
            s_gnt = 1'($urandom_range(0, 1));
            s_rvalid = q.size() != 0 && $urandom_range(0, 1) == 1;
            s_rdata = $urandom;
            s_rerr = 1'($urandom_range(0, 1));
            tick(g);
            if (g >= 0) req[g] = 1'b0;
        end
        settle();

`ifdef OBI_RR_ARBITER_STATS_EN
        begin
            logic [31:0] base;
            base = stall_cnt;
            req = 4'b0001;
            s_gnt = 1'b0;
            for (int c = 0; c < 5; c++) tick(g);
            chk("stall_cnt", stall_cnt - base, 32'd5);
            settle();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
